pkt_slip_tx: RTL

PKT_SLIP_TX -- requirements
Module: pkt_slip_tx

---
 rtl/pkt_slip_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pkt_slip_tx.sv
// SLIP frame encoder: drains a byte FIFO into a registered ready/valid byte stream.
// Optional CRC-8 trailer (poly 0x07) is built when SLIP_TX_CRC_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no packet in progress, waiting for a FIFO byte
// LEAD     | emit leading END (0xC0)
// DATA     | pop and emit a payload byte (or its ESC prefix)
// ESC2     | emit the held second code of an escaped payload byte
// CRC      | emit CRC byte (or its ESC prefix)          [SLIP_TX_CRC_EN]
// CRC_ESC2 | emit the held second code of an escaped CRC [SLIP_TX_CRC_EN]
// TERM     | emit trailing END (0xC0)
module pkt_slip_tx #(
    parameter int LEAD_END = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_empty,
    output logic       in_re,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [7:0] END_B   = 8'hC0;
    localparam logic [7:0] ESC_B   = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        DATA,
        ESC2,
`ifdef SLIP_TX_CRC_EN
        CRC,
        CRC_ESC2,
`endif
        TERM
    } state_t;

`ifdef SLIP_TX_CRC_EN
    localparam state_t AFTER_DATA = CRC;
`else
    localparam state_t AFTER_DATA = TERM;
`endif

    state_t     state;
    state_t     state_eff;
    logic       free;
    logic [7:0] esc_q;
    logic       last_q;

`ifdef SLIP_TX_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    function automatic logic is_special(input logic [7:0] b);
        return (b == END_B) || (b == ESC_B);
    endfunction

    function automatic logic [7:0] second_code(input logic [7:0] b);
        return (b == END_B) ? ESC_END : ESC_ESC;
    endfunction

    // IDLE leaves in the same cycle a byte appears, so the first code loads
    // one cycle after in_empty falls and packets follow TERM without a bubble.
    always_comb begin
        free      = !out_valid || out_ready;
        state_eff = state;
        if (state == IDLE && !in_empty)
            state_eff = (LEAD_END != 0) ? LEAD : DATA;
        in_re = !rst && (state_eff == DATA) && !in_empty && free;
    end

    assign busy = !rst && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            esc_q     <= 8'h00;
            last_q    <= 1'b0;
`ifdef SLIP_TX_CRC_EN
            crc       <= 8'h00;
`endif
        end else if (!free) begin
            state <= state_eff;
        end else begin
            out_valid <= 1'b0;
            state     <= state_eff;
            case (state_eff)
                IDLE: state <= IDLE;
                LEAD: begin
                    out_data  <= END_B;
                    out_valid <= 1'b1;
                    state     <= DATA;
                end
                DATA: begin
                    if (!in_empty) begin
                        out_valid <= 1'b1;
                        last_q    <= in_last;
`ifdef SLIP_TX_CRC_EN
                        crc       <= crc8_next(crc, in_data);
`endif
                        if (is_special(in_data)) begin
                            out_data <= ESC_B;
                            esc_q    <= second_code(in_data);
                            state    <= ESC2;
                        end else begin
                            out_data <= in_data;
                            state    <= in_last ? AFTER_DATA : DATA;
                        end
                    end
                end
                ESC2: begin
                    out_data  <= esc_q;
                    out_valid <= 1'b1;
                    state     <= last_q ? AFTER_DATA : DATA;
                end
`ifdef SLIP_TX_CRC_EN
                CRC: begin
                    out_valid <= 1'b1;
                    if (is_special(crc)) begin
                        out_data <= ESC_B;
                        esc_q    <= second_code(crc);
                        state    <= CRC_ESC2;
                    end else begin
                        out_data <= crc;
                        state    <= TERM;
                    end
                end
                CRC_ESC2: begin
                    out_data  <= esc_q;
                    out_valid <= 1'b1;
                    state     <= TERM;
                end
`endif
                TERM: begin
                    out_data  <= END_B;
                    out_valid <= 1'b1;
`ifdef SLIP_TX_CRC_EN
                    crc       <= 8'h00;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
